plb_miss_sequencer: RTL

- Initiator side of the PosMap/PLB command interface; drives the PLB's cmd, refill-data and response handshakes for every program access.
- Per access: update lookup. On miss: update the on-chip PosMap entry of the PosMap block, fetch or init-refill the block, buffer any evicted block and write it back, then retry. On hit: issue the leaf-pair data access to the backend.
- Sits between the frontend request stage and the PLB plus backend command/data queues.

---
 rtl/plb_miss_sequencer.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/plb_miss_sequencer.sv
// Per-access sequencer in front of the PLB: lookup, PosMap miss handling (fetch or init refill),
// evicted-block writeback and a single retry, then the leaf-pair data access to the backend.
module plb_miss_sequencer #(
    parameter int ORAMU = 32,
    parameter int ORAML = 10,
    parameter int LeafWidth = 32,
    parameter int LogLeafInBlock = 4,
    parameter logic [ORAMU-1:0] FinalPosMapStart = 32'h8000_0000
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 ReqValid,
    output logic                 ReqReady,
    input  logic [ORAMU-1:0]     ReqAddr,
    output logic                 PLBCmdValid,
    input  logic                 PLBCmdReady,
    output logic [1:0]           PLBCmd,
    output logic [ORAMU-1:0]     PLBAddr,
    output logic                 PLBDInValid,
    output logic [LeafWidth-1:0] PLBDIn,
    input  logic                 PLBRefillDataReady,
    output logic                 PLBOutReady,
    input  logic                 PLBValid,
    input  logic                 PLBHit,
    input  logic                 PLBUnInit,
    input  logic                 PLBEvict,
    input  logic [ORAML-1:0]     PLBOldLeaf,
    input  logic [ORAML-1:0]     PLBNewLeaf,
    input  logic [ORAMU-1:0]     PLBAddrOut,
    input  logic                 PLBEvictDataValid,
    input  logic [LeafWidth-1:0] PLBEvictData,
    output logic                 BEReqValid,
    input  logic                 BEReqReady,
    output logic [1:0]           BEReqCmd,
    output logic [ORAMU-1:0]     BEReqAddr,
    output logic [ORAML-1:0]     BEOldLeaf,
    output logic [ORAML-1:0]     BENewLeaf,
    output logic                 BEUnInit,
    input  logic                 BEDataInValid,
    output logic                 BEDataInReady,
    input  logic [LeafWidth-1:0] BEDataIn,
    output logic                 BEDataOutValid,
    input  logic                 BEDataOutReady,
    output logic [LeafWidth-1:0] BEDataOut,
    output logic                 Error
);
    localparam int N = 1 << LogLeafInBlock;
    localparam int CntW = LogLeafInBlock + 1;
    localparam logic [LogLeafInBlock-1:0] LastIdx = LogLeafInBlock'(N - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(N);
    localparam logic [ORAMU-1:0] LowMask = ORAMU'(N - 1);
    localparam logic [1:0] PlbUpdate = 2'b00;
    localparam logic [1:0] PlbRefill = 2'b10;
    localparam logic [1:0] PlbInitRefill = 2'b11;
    localparam logic [1:0] BeWriteback = 2'b00;
    localparam logic [1:0] BeFetch = 2'b01;
    localparam logic [1:0] BeAccess = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_LOOKUP_CMD  = 4'd1,
        S_LOOKUP_RSP  = 4'd2,
        S_PM_CMD      = 4'd3,
        S_PM_RSP      = 4'd4,
        S_FETCH_REQ   = 4'd5,
        S_REFILL_CMD  = 4'd6,
        S_REFILL_DATA = 4'd7,
        S_REFILL_RSP  = 4'd8,
        S_WB_REQ      = 4'd9,
        S_WB_DATA     = 4'd10,
        S_ACCESS_REQ  = 4'd11
    } state_t;

    state_t                    stateR, stateNextS;
    logic [ORAMU-1:0]          reqAddrR, pmAddrR, wbAddrR;
    logic [ORAML-1:0]          oldLeafR, newLeafR, wbLeafR;
    logic                      unInitR, retryR, errorR, fsmErrS;
    logic [1:0]                refillCmdR;
    logic [LogLeafInBlock-1:0] refillCntR, wbCntR;
    logic [CntW-1:0]           evictCntR;
    logic [LeafWidth-1:0]      evictBuf [N];
    logic                      inRefillS, captureS, evictErrS;

    assign inRefillS = (stateR == S_REFILL_CMD) || (stateR == S_REFILL_DATA) || (stateR == S_REFILL_RSP);
    assign captureS  = PLBEvictDataValid && inRefillS && (evictCntR != FullCnt);
    assign evictErrS = PLBEvictDataValid && !(inRefillS && (evictCntR != FullCnt));
    assign Error     = errorR;

    // Next-state decode and the handshake/payload outputs of the current state.
    always_comb begin
        stateNextS     = stateR;
        fsmErrS        = 1'b0;
        ReqReady       = 1'b0;
        PLBCmdValid    = 1'b0;
        PLBCmd         = PlbUpdate;
        PLBAddr        = {ORAMU{1'b0}};
        PLBDInValid    = 1'b0;
        PLBDIn         = {LeafWidth{1'b0}};
        BEDataInReady  = 1'b0;
        PLBOutReady    = 1'b0;
        BEReqValid     = 1'b0;
        BEReqCmd       = BeWriteback;
        BEReqAddr      = {ORAMU{1'b0}};
        BEOldLeaf      = {ORAML{1'b0}};
        BENewLeaf      = {ORAML{1'b0}};
        BEUnInit       = 1'b0;
        BEDataOutValid = 1'b0;
        BEDataOut      = {LeafWidth{1'b0}};
        case (stateR)
            S_IDLE: begin
                // Held low while Reset is asserted so every ready reads 0 during reset.
                ReqReady = Reset;
                if (ReqValid) stateNextS = S_LOOKUP_CMD;
                else          stateNextS = S_IDLE;
            end
            S_LOOKUP_CMD: begin
                PLBCmdValid = 1'b1;
                PLBAddr     = reqAddrR;
                if (PLBCmdReady) stateNextS = S_LOOKUP_RSP;
                else             stateNextS = S_LOOKUP_CMD;
            end
            S_LOOKUP_RSP: begin
                PLBOutReady = 1'b1;
                if (!PLBValid)   stateNextS = S_LOOKUP_RSP;
                else if (PLBHit) stateNextS = S_ACCESS_REQ;
                else if (retryR) begin
                    fsmErrS    = 1'b1;
                    stateNextS = S_IDLE;
                end else         stateNextS = S_PM_CMD;
            end
            S_PM_CMD: begin
                PLBCmdValid = 1'b1;
                PLBAddr     = pmAddrR;
                if (PLBCmdReady) stateNextS = S_PM_RSP;
                else             stateNextS = S_PM_CMD;
            end
            S_PM_RSP: begin
                PLBOutReady = 1'b1;
                if (!PLBValid) stateNextS = S_PM_RSP;
                else if (!PLBHit) begin
                    fsmErrS    = 1'b1;
                    stateNextS = S_IDLE;
                end else if (PLBUnInit) stateNextS = S_REFILL_CMD;
                else                    stateNextS = S_FETCH_REQ;
            end
            S_FETCH_REQ: begin
                BEReqValid = 1'b1;
                BEReqCmd   = BeFetch;
                BEReqAddr  = pmAddrR;
                BEOldLeaf  = oldLeafR;
                BENewLeaf  = newLeafR;
                if (BEReqReady) stateNextS = S_REFILL_CMD;
                else            stateNextS = S_FETCH_REQ;
            end
            S_REFILL_CMD: begin
                PLBCmdValid = 1'b1;
                PLBCmd      = refillCmdR;
                PLBAddr     = reqAddrR & ~LowMask;
                if (!PLBCmdReady)                  stateNextS = S_REFILL_CMD;
                else if (refillCmdR == PlbRefill)  stateNextS = S_REFILL_DATA;
                else                               stateNextS = S_REFILL_RSP;
            end
            S_REFILL_DATA: begin
                PLBDInValid   = BEDataInValid;
                PLBDIn        = BEDataIn;
                BEDataInReady = PLBRefillDataReady;
                if (BEDataInValid && PLBRefillDataReady && (refillCntR == LastIdx)) stateNextS = S_REFILL_RSP;
                else                                                             stateNextS = S_REFILL_DATA;
            end
            S_REFILL_RSP: begin
                PLBOutReady = 1'b1;
                if (!PLBValid)  stateNextS = S_REFILL_RSP;
                else if (!PLBEvict) stateNextS = S_LOOKUP_CMD;
                else if (evictCntR != FullCnt) begin
                    fsmErrS    = 1'b1;
                    stateNextS = S_IDLE;
                end else        stateNextS = S_WB_REQ;
            end
            S_WB_REQ: begin
                BEReqValid = 1'b1;
                BEReqCmd   = BeWriteback;
                BEReqAddr  = wbAddrR;
                BEOldLeaf  = wbLeafR;
                BENewLeaf  = wbLeafR;
                if (BEReqReady) stateNextS = S_WB_DATA;
                else            stateNextS = S_WB_REQ;
            end
            S_WB_DATA: begin
                BEDataOutValid = 1'b1;
                BEDataOut      = evictBuf[wbCntR];
                if (BEDataOutReady && (wbCntR == LastIdx)) stateNextS = S_LOOKUP_CMD;
                else                                      stateNextS = S_WB_DATA;
            end
            S_ACCESS_REQ: begin
                BEReqValid = 1'b1;
                BEReqCmd   = BeAccess;
                BEReqAddr  = reqAddrR;
                BEOldLeaf  = oldLeafR;
                BENewLeaf  = newLeafR;
                BEUnInit   = unInitR;
                if (BEReqReady) stateNextS = S_IDLE;
                else            stateNextS = S_ACCESS_REQ;
            end
            default: begin
                fsmErrS    = 1'b1;
                stateNextS = S_IDLE;
            end
        endcase
    end

    // State register, per-access context latches, retry flag and sticky error.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            stateR     <= S_IDLE;
            reqAddrR   <= {ORAMU{1'b0}};
            pmAddrR    <= {ORAMU{1'b0}};
            wbAddrR    <= {ORAMU{1'b0}};
            oldLeafR   <= {ORAML{1'b0}};
            newLeafR   <= {ORAML{1'b0}};
            wbLeafR    <= {ORAML{1'b0}};
            unInitR    <= 1'b0;
            refillCmdR <= PlbRefill;
            retryR     <= 1'b0;
            errorR     <= 1'b0;
        end else begin
            stateR <= stateNextS;
            if ((stateR == S_IDLE) && ReqValid) begin
                reqAddrR <= ReqAddr;
                pmAddrR  <= FinalPosMapStart + (ReqAddr >> LogLeafInBlock);
            end
            if (PLBValid && ((stateR == S_LOOKUP_RSP) || (stateR == S_PM_RSP))) begin
                oldLeafR <= PLBOldLeaf;
                newLeafR <= PLBNewLeaf;
                unInitR  <= PLBUnInit;
            end
            if (PLBValid && (stateR == S_PM_RSP)) begin
                refillCmdR <= PLBUnInit ? PlbInitRefill : PlbRefill;
            end
            if (PLBValid && PLBEvict && (stateR == S_REFILL_RSP)) begin
                wbAddrR <= FinalPosMapStart + (PLBAddrOut >> LogLeafInBlock);
                wbLeafR <= PLBNewLeaf;
            end
            // Any re-entry into LOOKUP_CMD other than from IDLE is the one allowed retry.
            if (stateR == S_IDLE) begin
                retryR <= 1'b0;
            end else if ((stateNextS == S_LOOKUP_CMD) && (stateR != S_LOOKUP_CMD)) begin
                retryR <= 1'b1;
            end
            errorR <= errorR | fsmErrS | evictErrS;
        end
    end

    // Refill, writeback and evict-capture word counters.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            refillCntR <= {LogLeafInBlock{1'b0}};
            wbCntR     <= {LogLeafInBlock{1'b0}};
            evictCntR  <= {CntW{1'b0}};
        end else begin
            if (stateR == S_REFILL_CMD) begin
                refillCntR <= {LogLeafInBlock{1'b0}};
            end else if ((stateR == S_REFILL_DATA) && BEDataInValid && PLBRefillDataReady) begin
                refillCntR <= refillCntR + 1'b1;
            end
            if (stateR == S_WB_REQ) begin
                wbCntR <= {LogLeafInBlock{1'b0}};
            end else if ((stateR == S_WB_DATA) && BEDataOutReady) begin
                wbCntR <= wbCntR + 1'b1;
            end
            if ((stateR == S_IDLE) || (stateR == S_LOOKUP_CMD)) begin
                evictCntR <= {CntW{1'b0}};
            end else if (captureS) begin
                evictCntR <= evictCntR + 1'b1;
            end
        end
    end

    // Evict buffer storage; only entries below the capture count are meaningful.
    always_ff @(posedge Clock) begin
        if (captureS) begin
            evictBuf[evictCntR[LogLeafInBlock-1:0]] <= PLBEvictData;
        end
    end
endmodule
